// File: rtl/async_fifo_pkg.sv
// Pointer helpers shared by the write-side full block and the read-side empty block of the async FIFO.
// Gray/binary conversions work on a fixed-width word; callers size-cast to their own pointer width.
package async_fifo_pkg;

  localparam int PTR_MAX_W = 32;

  typedef logic [PTR_MAX_W-1:0] ptrWord_t;

  // One extra bit beyond the address distinguishes a full FIFO from an empty one.
  function automatic int ptrWidth(input int asize);
    return asize + 1;
  endfunction

  function automatic int fifoDepth(input int asize);
    return 1 << asize;
  endfunction

  function automatic ptrWord_t bin2gray(input ptrWord_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptrWord_t gray2bin(input ptrWord_t g);
    ptrWord_t b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter of width W.
// Only compiled when ASYNC_FIFO_AFULL_EN is defined, since the almost-full path is its sole user.
`ifdef ASYNC_FIFO_AFULL_EN
module gray2bin
  import async_fifo_pkg::*;
#(
  parameter int W = 5
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  assign bin_o = W'(async_fifo_pkg::gray2bin(ptrWord_t'(gray_i)));

endmodule
`endif

// File: rtl/wptr_full.sv
// Write-side pointer and full/almost-full/overflow flag generation for an asynchronous FIFO.
// Optional almost-full logic is built only when the macro ASYNC_FIFO_AFULL_EN is defined.
module wptr_full
  import async_fifo_pkg::*;
#(
  parameter int ASIZE        = 4,
  parameter int AFULL_MARGIN = 1
) (
  input  logic             wclk,
  input  logic             wrst,
  input  logic             winc,
  input  logic [ASIZE:0]   wq2_rptr,
  output logic [ASIZE-1:0] waddr,
  output logic [ASIZE:0]   wptr,
  output logic             wfull,
  output logic             awfull,
  output logic             wovf
);

  localparam int PW    = ptrWidth(ASIZE);
  localparam int DEPTH = fifoDepth(ASIZE);

  if (ASIZE < 2 || AFULL_MARGIN < 1 || AFULL_MARGIN >= DEPTH) begin : g_badParams
    $error("wptr_full: ASIZE must be >= 2 and AFULL_MARGIN within 1..2**ASIZE-1");
  end

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic          wfull_q, wfull_d;
  logic          wovf_q, wovf_d;
  logic [PW-1:0] fullPattern;

  // Full when our next Gray pointer equals the read pointer with its two MSBs inverted.
  always_comb begin
    fullPattern = {~wq2_rptr[ASIZE:ASIZE-1], wq2_rptr[ASIZE-2:0]};
    wbin_d      = wbin_q + PW'(winc & ~wfull_q);
    wptr_d      = PW'(bin2gray(ptrWord_t'(wbin_d)));
    wfull_d     = (wptr_d == fullPattern);
    wovf_d      = wovf_q | (winc & wfull_q);
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin_q  <= '0;
      wptr_q  <= '0;
      wfull_q <= 1'b0;
      wovf_q  <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wptr_q  <= wptr_d;
      wfull_q <= wfull_d;
      wovf_q  <= wovf_d;
    end
  end

  assign waddr = wbin_q[ASIZE-1:0];
  assign wptr  = wptr_q;
  assign wfull = wfull_q;
  assign wovf  = wovf_q;

`ifdef ASYNC_FIFO_AFULL_EN
  localparam logic [PW-1:0] AFULL_THRESH = PW'(DEPTH - AFULL_MARGIN);

  logic [PW-1:0] rbin;
  logic [PW-1:0] occ;
  logic          awfull_q, awfull_d;

  gray2bin #(.W(PW)) u_rptrBin (
    .gray_i(wq2_rptr),
    .bin_o (rbin)
  );

  // Occupancy uses the post-write pointer so the flag lines up with wfull.
  always_comb begin
    occ      = wbin_d - rbin;
    awfull_d = (occ >= AFULL_THRESH);
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      awfull_q <= 1'b0;
    end else begin
      awfull_q <= awfull_d;
    end
  end

  assign awfull = awfull_q;
`else
  assign awfull = 1'b0;
`endif

endmodule
